// File: rtl/mc_datapath_if.sv
// Instruction and data memory ports of the multi-cycle core.
// master = core side, slave = memory side; req/ready handshakes.
interface mc_datapath_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rdata,
    output dmem_req, dmem_wen, dmem_addr,
    output dmem_be, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rdata,
    input  dmem_req, dmem_wen, dmem_addr,
    input  dmem_be, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mc_datapath.sv
// Multi-cycle RV32I/E core: FETCH/EXEC/MEM/WB/HALT over mc_datapath_if.
// Ports: clk, nrst (sync, active-low), mem (master), retire, pc_out, halted, trap.
module mc_datapath #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          NREGS         = 32,
  parameter bit          TRAP_MISALIGN = 1'b1
) (
  input  logic          clk,
  input  logic          nrst,
  mc_datapath_if.master mem,
  output logic          retire,
  output logic [31:0]   pc_out,
  output logic          halted,
  output logic          trap
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t state, state_n;

  logic [31:0] pc, ir, npc, res, maddr, wdata;
  logic [3:0]  be;
  logic        wen, trap_q, trap_set;
  logic [31:0] rf [NREGS];

  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign rd  = ir[11:7];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0};

  logic is_lui, is_auipc, is_jal, is_jalr, is_br;
  logic is_ld, is_st, is_opi, is_op, is_fen, is_sys;
  assign is_lui   = opc == 7'h37;
  assign is_auipc = opc == 7'h17;
  assign is_jal   = opc == 7'h6F;
  assign is_jalr  = opc == 7'h67;
  assign is_br    = opc == 7'h63;
  assign is_ld    = opc == 7'h03;
  assign is_st    = opc == 7'h23;
  assign is_opi   = opc == 7'h13;
  assign is_op    = opc == 7'h33;
  assign is_fen   = opc == 7'h0F;
  assign is_sys   = opc == 7'h73;

  logic ill, bad_enc, u1, u2, ud;
  always_comb begin
    bad_enc = 1'b0;
    u1 = 1'b0;
    u2 = 1'b0;
    ud = 1'b0;
    unique case (1'b1)
      is_lui, is_auipc, is_jal: ud = 1'b1;
      is_jalr: begin
        u1 = 1'b1; ud = 1'b1;
        bad_enc = f3 != 3'd0;
      end
      is_br: begin
        u1 = 1'b1; u2 = 1'b1;
        bad_enc = f3[2:1] == 2'b01;
      end
      is_ld: begin
        u1 = 1'b1; ud = 1'b1;
        bad_enc = f3 == 3'd3 || f3 > 3'd5;
      end
      is_st: begin
        u1 = 1'b1; u2 = 1'b1;
        bad_enc = f3 > 3'd2;
      end
      is_opi: begin
        u1 = 1'b1; ud = 1'b1;
        bad_enc = (f3 == 3'd1 && ir[31:25] != 7'h0)
               || (f3 == 3'd5 && {ir[31], ir[29:25]} != 6'h0);
      end
      is_op: begin
        u1 = 1'b1; u2 = 1'b1; ud = 1'b1;
        bad_enc = ir[31:25] != 7'h0
               && !(ir[31:25] == 7'h20
                    && (f3 == 3'd0 || f3 == 3'd5));
      end
      is_fen: bad_enc = 1'b0;
      is_sys: bad_enc = ir[31:7] != 25'h0
                     && ir[31:7] != 25'h2000;
      default: bad_enc = 1'b1;
    endcase
  end

  // RV32E: any register field the instruction uses must be < NREGS
  assign ill = bad_enc
    || (u1 && {27'b0, rs1} >= 32'(NREGS))
    || (u2 && {27'b0, rs2} >= 32'(NREGS))
    || (ud && {27'b0, rd}  >= 32'(NREGS));

  logic [31:0] a, b, bop, alu;
  assign a   = rf[rs1[AW-1:0]];
  assign b   = rf[rs2[AW-1:0]];
  assign bop = is_op ? b : imm_i;

  always_comb begin
    unique case (f3)
      3'd0: alu = (is_op && ir[30]) ? a - bop : a + bop;
      3'd1: alu = a << bop[4:0];
      3'd2: alu = {31'b0, $signed(a) < $signed(bop)};
      3'd3: alu = {31'b0, a < bop};
      3'd4: alu = a ^ bop;
      3'd5: alu = ir[30] ? 32'($signed(a) >>> bop[4:0])
                         : a >> bop[4:0];
      3'd6: alu = a | bop;
      default: alu = a & bop;
    endcase
  end

  logic take;
  always_comb begin
    unique case (f3)
      3'd0: take = a == b;
      3'd1: take = a != b;
      3'd4: take = $signed(a) < $signed(b);
      3'd5: take = $signed(a) >= $signed(b);
      3'd6: take = a < b;
      3'd7: take = a >= b;
      default: take = 1'b0;
    endcase
  end

  logic [31:0] pc4, jr_t, tgt, npc_x, wres;
  logic        redir, mis_jmp;
  assign pc4   = pc + 32'd4;
  assign jr_t  = (a + imm_i) & ~32'd1;
  assign redir = is_jal || is_jalr || (is_br && take);
  assign tgt   = is_jal  ? pc + imm_j :
                 is_jalr ? jr_t :
                 redir   ? pc + imm_b : pc4;
  assign mis_jmp = redir && tgt[1];
  assign npc_x   = TRAP_MISALIGN ? tgt : {tgt[31:2], 2'b00};
  assign wres    = is_lui   ? imm_u :
                   is_auipc ? pc + imm_u :
                   (is_jal || is_jalr) ? pc4 : alu;

  logic [31:0] ea, ea_al;
  logic        ldst, mis_mem;
  assign ldst = is_ld || is_st;
  assign ea   = a + (is_st ? imm_s : imm_i);
  assign mis_mem = ldst && ((f3[1:0] == 2'd1 && ea[0])
                 || (f3[1:0] == 2'd2 && ea[1:0] != 2'd0));

  always_comb begin
    ea_al = ea;
    if (!TRAP_MISALIGN) begin
      if (f3[1])      ea_al[1:0] = 2'b00;
      else if (f3[0]) ea_al[0]   = 1'b0;
    end
  end

  logic [3:0]  be_x;
  logic [31:0] ld_sh, ld_val;
  always_comb begin
    unique case (f3[1:0])
      2'd0:    be_x = 4'b0001 << ea_al[1:0];
      2'd1:    be_x = 4'b0011 << {ea_al[1], 1'b0};
      default: be_x = 4'b1111;
    endcase
  end

  assign ld_sh = mem.dmem_rdata >> {maddr[1:0], 3'b000};
  always_comb begin
    unique case (f3)
      3'd0:    ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'd1:    ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'd4:    ld_val = {24'b0, ld_sh[7:0]};
      3'd5:    ld_val = {16'b0, ld_sh[15:0]};
      default: ld_val = ld_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) state <= S_FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    trap_set = 1'b0;
    unique case (state)
      S_FETCH: if (mem.imem_ready) state_n = S_EXEC;
      S_EXEC: begin
        if (ill) begin
          state_n  = S_HALT;
          trap_set = 1'b1;
        end else if (is_sys) begin
          state_n = S_HALT;
        end else if (TRAP_MISALIGN && (mis_mem || mis_jmp)) begin
          state_n  = S_HALT;
          trap_set = 1'b1;
        end else begin
          state_n = ldst ? S_MEM : S_WB;
        end
      end
      S_MEM:   if (mem.dmem_ready) state_n = S_WB;
      S_WB:    state_n = S_FETCH;
      default: state_n = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pc     <= RESET_PC;
      ir     <= '0;
      npc    <= '0;
      res    <= '0;
      maddr  <= '0;
      wdata  <= '0;
      be     <= '0;
      wen    <= 1'b0;
      trap_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      unique case (state)
        S_FETCH: if (mem.imem_ready) ir <= mem.imem_rdata;
        S_EXEC: begin
          res   <= wres;
          npc   <= npc_x;
          maddr <= ea_al;
          be    <= be_x;
          wdata <= b << {ea_al[1:0], 3'b000};
          wen   <= is_st;
          if (trap_set) trap_q <= 1'b1;
        end
        S_MEM: if (mem.dmem_ready && !wen) res <= ld_val;
        S_WB: begin
          pc <= npc;
          if (ud && rd != 5'd0) rf[rd[AW-1:0]] <= res;
        end
        default: ;
      endcase
    end
  end

  // Requests are masked while nrst is low so a reset cancels them at once
  assign mem.imem_req   = nrst && state == S_FETCH;
  assign mem.imem_addr  = pc;
  assign mem.dmem_req   = nrst && state == S_MEM;
  assign mem.dmem_wen   = wen;
  assign mem.dmem_addr  = {maddr[31:2], 2'b00};
  assign mem.dmem_be    = be;
  assign mem.dmem_wdata = wdata;

  assign retire = state == S_WB;
  assign pc_out = pc;
  assign halted = state == S_HALT;
  assign trap   = trap_q;
endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath with small imem/dmem models.
// Checks retire timing, loads/stores, branches, stalls, traps, reset.
module tb_mc_datapath;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        retire, halted, trap;
  logic [31:0] pc_out;

  mc_datapath_if mif ();

  mc_datapath #(
    .RESET_PC(32'h0), .NREGS(32), .TRAP_MISALIGN(1'b1)
  ) dut (
    .clk(clk), .nrst(nrst), .mem(mif),
    .retire(retire), .pc_out(pc_out),
    .halted(halted), .trap(trap)
  );

  always #5 clk = ~clk;

  logic [31:0] prog [64];
  logic [31:0] dm [64];
  bit auto_i, auto_d, pulse_i;
  int ncmp = 0, nfail = 0;
  int cyc, dreq_n, exec_n;
  int rq [$];
  logic [31:0] first_daddr, st_addr, st_wdata;
  logic [3:0]  st_be;

  initial begin
    mif.imem_ready = 1'b0;
    mif.imem_rdata = '0;
    mif.dmem_ready = 1'b0;
    mif.dmem_rdata = '0;
  end

  // memory responder, updated away from the active edge
  always @(negedge clk) begin
    mif.imem_ready = (auto_i && mif.imem_req) || pulse_i;
    mif.imem_rdata = prog[mif.imem_addr[7:2]];
    mif.dmem_ready = auto_d && mif.dmem_req;
    mif.dmem_rdata = dm[mif.dmem_addr[7:2]];
    if (mif.dmem_ready && mif.dmem_wen)
      for (int k = 0; k < 4; k++)
        if (mif.dmem_be[k])
          dm[mif.dmem_addr[7:2]][k*8 +: 8] = mif.dmem_wdata[k*8 +: 8];
  end

  always @(posedge clk)
    if (!nrst) cyc <= 0;
    else       cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!nrst) begin
      rq.delete();
      dreq_n = 0;
      exec_n = 0;
    end else begin
      if (retire) rq.push_back(cyc + 1);
      if (dut.state == 3'd1) exec_n++;
      if (mif.dmem_req) begin
        dreq_n++;
        if (dreq_n == 1) first_daddr = mif.dmem_addr;
        if (mif.dmem_wen) begin
          st_addr  = mif.dmem_addr;
          st_be    = mif.dmem_be;
          st_wdata = mif.dmem_wdata;
        end
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] r1,
      logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm, r1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] r2,
      logic [4:0] r1, logic [2:0] f3, logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] r2,
      logic [4:0] r1, logic [2:0] f3);
    return {imm[11:5], r2, r1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] r2,
      logic [4:0] r1, logic [2:0] f3);
    return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  task automatic clr();
    for (int i = 0; i < 64; i++) begin
      prog[i] = EBREAK;
      dm[i]   = '0;
    end
  endtask

  task automatic do_reset(bit ai, bit ad);
    nrst = 1'b0;
    auto_i = ai;
    auto_d = ad;
    pulse_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic wait_halt(string tag, int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!halted && n < max);
    chk(tag, {31'b0, halted}, 32'd1);
  endtask

  task automatic wait_ret_pc(string tag, logic [31:0] p, int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(retire && pc_out == p) && n < max);
    chk(tag, {31'b0, retire && pc_out == p}, 32'd1);
  endtask

  initial begin
    // ADDI / ADD, zero-wait memory, retire timing
    clr();
    prog[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
    prog[1] = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
    nrst = 1'b0;
    auto_i = 1'b1;
    auto_d = 1'b1;
    pulse_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_iaddr", mif.imem_addr, 32'h0);
    chk("rst_ireq", {31'b0, mif.imem_req}, 32'd0);
    chk("rst_dreq", {31'b0, mif.dmem_req}, 32'd0);
    chk("rst_retire", {31'b0, retire}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_trap", {31'b0, trap}, 32'd0);
    nrst = 1'b1;
    wait_halt("t1_halt", 40);
    chk("t1_nret", 32'(rq.size()), 32'd2);
    chk("t1_ret0", rq.size() > 0 ? 32'(rq[0]) : 32'hFFFF_FFFF, 32'd3);
    chk("t1_ret1", rq.size() > 1 ? 32'(rq[1]) : 32'hFFFF_FFFF, 32'd6);
    chk("t1_x2", dut.rf[2], 32'd10);
    chk("t1_pc", pc_out, 32'h8);
    chk("t1_trap", {31'b0, trap}, 32'd0);

    // loads with sign/zero extension and a halfword store
    clr();
    dm[0]   = 32'h8000_00F0;
    prog[0] = enc_i(12'h100, 5'd0, 3'd0, 5'd1, 7'h13);
    prog[1] = enc_i(12'd3, 5'd1, 3'd0, 5'd3, 7'h03);
    prog[2] = enc_i(12'd3, 5'd1, 3'd4, 5'd4, 7'h03);
    prog[3] = enc_i(12'd2, 5'd1, 3'd1, 5'd5, 7'h03);
    prog[4] = {20'h00001, 5'd2, 7'h37};
    prog[5] = enc_i(12'h234, 5'd2, 3'd0, 5'd2, 7'h13);
    prog[6] = enc_s(12'd2, 5'd2, 5'd1, 3'd1);
    prog[7] = enc_i(12'd0, 5'd1, 3'd2, 5'd6, 7'h03);
    do_reset(1'b1, 1'b1);
    wait_halt("t2_halt", 200);
    chk("t2_lb_ret", rq.size() > 1 ? 32'(rq[1]) : 32'hFFFF_FFFF, 32'd7);
    chk("t2_daddr", first_daddr, 32'h100);
    chk("t2_lb", dut.rf[3], 32'hFFFF_FF80);
    chk("t2_lbu", dut.rf[4], 32'h0000_0080);
    chk("t2_lh", dut.rf[5], 32'hFFFF_8000);
    chk("t2_st_be", {28'b0, st_be}, 32'hC);
    chk("t2_st_wd", st_wdata, 32'h1234_0000);
    chk("t2_st_addr", st_addr, 32'h100);
    chk("t2_lw", dut.rf[6], 32'h1234_00F0);
    chk("t2_trap", {31'b0, trap}, 32'd0);

    // BEQ taken backwards from 0x20
    clr();
    for (int i = 0; i < 8; i++) prog[i] = NOP;
    prog[8] = enc_b(13'h1FF8, 5'd0, 5'd0, 3'd0);
    do_reset(1'b1, 1'b1);
    wait_ret_pc("t3_beq_ret", 32'h20, 100);
    @(negedge clk);
    chk("t3_beq_tgt", mif.imem_addr, 32'h18);

    // BNE not taken falls through to ECALL
    prog[8] = enc_b(13'h1FF8, 5'd0, 5'd0, 3'd1);
    prog[9] = ECALL;
    do_reset(1'b1, 1'b1);
    wait_ret_pc("t3_bne_ret", 32'h20, 100);
    @(negedge clk);
    chk("t3_bne_tgt", mif.imem_addr, 32'h24);
    wait_halt("t3_halt", 20);
    chk("t3_ecall_trap", {31'b0, trap}, 32'd0);

    // JAL then JALR with an odd sum (bit 0 cleared)
    clr();
    prog[0] = enc_j(21'd12, 5'd1);
    prog[1] = 32'hFFFF_FFFF;
    prog[2] = 32'hFFFF_FFFF;
    prog[3] = enc_i(12'd13, 5'd1, 3'd0, 5'd5, 7'h67);
    do_reset(1'b1, 1'b1);
    wait_halt("t4_halt", 40);
    chk("t4_x1", dut.rf[1], 32'h4);
    chk("t4_x5", dut.rf[5], 32'h10);
    chk("t4_pc", pc_out, 32'h10);
    chk("t4_trap", {31'b0, trap}, 32'd0);

    // fetch stall, then a 3-cycle ready pulse (late part ignored)
    clr();
    prog[0] = enc_i(12'd7, 5'd0, 3'd0, 5'd1, 7'h13);
    do_reset(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_iaddr", mif.imem_addr, 32'h0);
      chk("t5_ireq", {31'b0, mif.imem_req}, 32'd1);
    end
    @(posedge clk);
    #1 pulse_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 pulse_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_exec_n", 32'(exec_n), 32'd1);
    chk("t5_x1", dut.rf[1], 32'd7);
    chk("t5_pc", pc_out, 32'h4);
    chk("t5_halted", {31'b0, halted}, 32'd0);

    // misaligned LW traps with no data request
    clr();
    prog[0] = enc_i(12'h100, 5'd0, 3'd0, 5'd1, 7'h13);
    prog[1] = enc_i(12'd2, 5'd1, 3'd2, 5'd2, 7'h03);
    do_reset(1'b1, 1'b1);
    wait_halt("t6_halt", 40);
    chk("t6_trap", {31'b0, trap}, 32'd1);
    chk("t6_dreq_n", 32'(dreq_n), 32'd0);
    chk("t6_pc", pc_out, 32'h4);

    // MUL encoding is illegal in RV32I
    clr();
    prog[0] = enc_r(7'h01, 5'd1, 5'd1, 3'd0, 5'd2);
    do_reset(1'b1, 1'b1);
    wait_halt("t7_halt", 20);
    chk("t7_trap", {31'b0, trap}, 32'd1);

    // reset in the middle of a stalled load
    clr();
    prog[0] = enc_i(12'h100, 5'd0, 3'd0, 5'd1, 7'h13);
    prog[1] = enc_i(12'd0, 5'd1, 3'd2, 5'd2, 7'h03);
    do_reset(1'b1, 1'b0);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!mif.dmem_req && n < 30);
    end
    chk("t8_dreq_seen", {31'b0, mif.dmem_req}, 32'd1);
    chk("t8_x1_pre", dut.rf[1], 32'h100);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    chk("t8_dreq", {31'b0, mif.dmem_req}, 32'd0);
    chk("t8_pc", pc_out, 32'h0);
    chk("t8_x1", dut.rf[1], 32'h0);
    @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    chk("t8_refetch", {31'b0, mif.imem_req}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
